// File: rtl/ucode_sequencer.sv
// Micro-code sequencer: walks control memory from a start address, decodes each
// control word into a one-hot micro-op type and issues it over valid/ready.
module ucode_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int CW_W      = 24,
    parameter int NUM_TYPES = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] cm_addr,
    output logic              cm_rd,
    input  logic [CW_W-1:0]   cm_data,
    input  logic              cond_flag,
    output logic [15:0]       instr_type,
    output logic [CW_W-7:0]   operand,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DECODE = 2'd2,
        ISSUE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] upc;
    logic              last_q;

    // Control word fields, valid on cm_data during DECODE.
    logic [3:0]        cw_type;
    logic              cw_jmp;
    logic              cw_last;
    logic [ADDR_W-1:0] cw_target;
    logic              cw_legal;
    logic              handshake;

    assign cw_type   = cm_data[CW_W-1:CW_W-4];
    assign cw_jmp    = cm_data[CW_W-5];
    assign cw_last   = cm_data[CW_W-6];
    assign cw_target = cm_data[ADDR_W-1:0];
    assign cw_legal  = int'(cw_type) < NUM_TYPES;
    assign handshake = op_valid && op_ready;

    assign cm_addr = upc;
    assign cm_rd   = (state == FETCH);
    assign busy    = (state != IDLE);

    // NOTE: every signal written in always_comb gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = DECODE;
            DECODE:  state_next = cw_legal ? ISSUE : IDLE;
            ISSUE: begin
                if (handshake) state_next = last_q ? IDLE : FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            upc        <= '0;
            last_q     <= 1'b0;
            instr_type <= '0;
            operand    <= '0;
            op_valid   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            err   <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (start) upc <= start_addr;
                end
                DECODE: begin
                    if (cw_legal) begin
                        instr_type <= 16'(1) << cw_type;
                        operand    <= cm_data[CW_W-7:0];
                        op_valid   <= 1'b1;
                        last_q     <= cw_last;
                        // Wraps naturally at the address width.
                        upc        <= (cw_jmp && cond_flag) ? cw_target : upc + 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (handshake) begin
                        op_valid   <= 1'b0;
                        instr_type <= '0;
                        done       <= last_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
- Micro-code sequencer for the PIM controller.
- On a start request it walks control memory from a given micro-address and fetches each control word (CW).
- Decodes the 4-bit CW type field into a one-hot instruction-type vector and issues it to the execution units over a valid/ready handshake.
- Resolves conditional jumps and terminates on the CW "last" bit; sits between the host command interface and the INIT/CMASK/MASK/TEMP/LUI/PIM_Load/L-S/V/VV/I units.

Parameters:
- ADDR_W, 8, micro-address width; control memory depth 2^ADDR_W.
- CW_W, 24, control word width.
- NUM_TYPES, 10, number of legal type codes (0..NUM_TYPES-1).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  start pulse; sampled only in IDLE.
- start_addr  input  ADDR_W  first micro-address of the routine.
- cm_addr  output  ADDR_W  control memory read address.
- cm_rd  output  1  control memory read enable.
- cm_data  input  CW_W  control word; valid the cycle after cm_rd (1-cycle synchronous read).
- cond_flag  input  1  jump condition from datapath, sampled in DECODE.
- instr_type  output  16  one-hot type of the issued micro-op; bit n = type code n.
- operand  output  CW_W-6  CW[CW_W-7:0], passed through with the issue.
- op_valid  output  1  issue valid.
- op_ready  input  1  target unit accepts.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a routine completes.
- err  output  1  one-cycle pulse on an illegal type code.

Behaviour:
- CW layout:
  - [CW_W-1:CW_W-4] type.
  - [CW_W-5] jmp: conditional jump.
  - [CW_W-6] last.
  - [ADDR_W-1:0] jump target; overlaps operand.
- Reset:
  - FSM goes to IDLE; uPC=0.
  - cm_rd=0, cm_addr=0, instr_type=0, operand=0, op_valid=0, busy=0, done=0, err=0.
- FSM states: IDLE, FETCH, DECODE, ISSUE.
- IDLE:
  - start=1 loads uPC=start_addr and moves to FETCH.
- FETCH:
  - cm_rd=1 and cm_addr=uPC for exactly 1 cycle, then DECODE.
- DECODE, with the CW from cm_data registered into a CW register:
  - type >= NUM_TYPES: err pulses, go to IDLE, nothing issued.
  - Otherwise instr_type=1<<type, operand and op_valid=1 are registered, go to ISSUE.
  - Next uPC = target if jmp && cond_flag, else uPC+1.
  - uPC increment wraps modulo 2^ADDR_W: 2^ADDR_W-1 goes to 0.
- ISSUE:
  - op_valid, instr_type and operand stay stable until op_ready=1.
  - On handshake (op_valid && op_ready), in the same cycle's update: op_valid=0 and instr_type=0.
  - If last=1: done pulses next cycle and the FSM goes to IDLE.
  - Else go to FETCH with the updated uPC.
  - If op_ready is already 1 on the first ISSUE cycle, ISSUE lasts 1 cycle.
- Throughput: at best one micro-op every 3 cycles (FETCH, DECODE, ISSUE).
- instr_type is 0 whenever op_valid=0. Bits [15:NUM_TYPES] are always 0.
- start while busy=1 is ignored and does not queue.
- A CW with both jmp=1 and last=1 terminates; the jump is ignored.
- rst asserted in any state aborts immediately to reset values. An in-flight op_valid drops the next edge with no handshake.
- done and err never assert in the same cycle.
- busy=1 on the cycle after start is accepted, and stays 1 through the cycle of the final handshake.

Test Plan:
- Reset, then start with start_addr=0x10. Memory holds 0x10 type 3, 0x11 type 8 with last=1, op_ready tied 1 -> instr_type=0x0008 issued, then 0x0100; done pulses once; busy falls; cm_addr sequence 0x10, 0x11.
- Backpressure: op_ready held 0 for 5 cycles during ISSUE -> op_valid, instr_type and operand stable all 5 cycles; exactly one handshake; next FETCH only after it.
- Jump: CW at 0x20 has jmp=1, target=0x40. With cond_flag=1 the next cm_addr is 0x40; repeat with cond_flag=0 and the next cm_addr is 0x21.
- Wrap: start_addr=0xFF with a non-last CW -> next cm_addr=0x00.
- Illegal type 12 at start_addr -> err pulses, op_valid never asserts, FSM back in IDLE, busy=0.
- rst asserted in ISSUE with op_valid=1 -> next cycle op_valid=0, busy=0, instr_type=0. A start issued while busy is ignored: cm_addr does not jump.
